mano_io_ctrl: RTL and testbench
===============================

# mano_io_ctrl

Character I/O controller for the Mano machine core. It owns the INPR register and the FGI, FGO and IEN flags, and generates the interrupt request R. It bridges a host-side byte stream (valid/ready, in and out) to the CPU's INP, OUT, ION and IOF instructions and its interrupt-cycle acknowledge. It sits between the CPU top level and the board I/O, and replaces direct testbench driving of the io_fgiset, io_fgoset and io_inpr pins.

## Interface
- DATA_W, 8: character width; INPR/OUTR width.
- FIFO_DEPTH, 4: input buffer depth; power of two ≥2; only meaningful with MANO_IO_INFIFO_EN.

Ports:
- io_clock  in  1  sole clock, rising edge.
- io_reset_n  in  1  asynchronous active-low reset.
- io_rx_valid  in  1  host has an input character.
- io_rx_data  in  DATA_W  host input character.
- io_rx_ready  out  1  controller accepts the character this cycle.
- io_tx_valid  out  1  output character pending.
- io_tx_data  out  DATA_W  OUTR contents.
- io_tx_ready  in  1  host consumes the character.
- io_cpu_inp  in  1  INP executing; CPU samples io_inpr this cycle.
- io_cpu_out  in  1  OUT executing; io_cpu_ac is loaded into OUTR.
- io_cpu_ac  in  DATA_W  AC(0-7).
- io_cpu_ion / io_cpu_iof  in  1  ION / IOF executing.
- io_cpu_int_ack  in  1  interrupt cycle entered.
- io_inpr  out  DATA_W  INPR register.
- io_fgi / io_fgo / io_ien  out  1  flags.
- io_int_req  out  1  R = IEN & (FGI | FGO).
- io_err  out  1  sticky protocol-error flag.

## Operation
- Reset values: inpr=0, fgi=0, fgo=1, ien=0, OUTR=0, tx_valid=0, err=0, output FSM in OUT_IDLE, FIFO empty.
- Input path (direct):
  - io_rx_ready = ~fgi.
  - An accept (rx_valid & rx_ready) loads inpr and sets fgi.
  - io_cpu_inp with fgi=1 clears fgi.
  - io_cpu_inp with fgi=0 sets err; inpr is unchanged.
- Output FSM:
  - OUT_IDLE: fgo=1, tx_valid=0. io_cpu_out loads OUTR and moves to OUT_SEND.
  - OUT_SEND: fgo=0, tx_valid=1, tx_data held stable. tx_valid & tx_ready returns to OUT_IDLE.
  - io_cpu_out in OUT_SEND sets err; OUTR is unchanged and the character is dropped.
- IEN priority: int_ack > iof > ion. ion sets IEN; iof and int_ack clear it.
- io_int_req is decoded only from registered state, with no combinational path from inputs.
- err clears only on reset.
- All CPU strobes are single-cycle pulses. A strobe held high acts once per cycle asserted.

## Timing
- rx accept at edge N: inpr/fgi valid after edge N (no FIFO). io_int_req follows in the same cycle if ien=1.
- cpu_inp at edge N: fgi=0 and rx_ready=1 after N. The next accept can occur in that cycle.
- cpu_out at edge N: tx_valid=1 and fgo=0 after N. With tx_ready already high, the handshake completes at N+1 and fgo=1 after N+1.
- Reset mid-transfer: the pending tx character is discarded and FIFO contents are lost. No tx_valid glitch: it is a flop output cleared asynchronously.
- Simultaneous cpu_out and tx completion cannot occur, because cpu_out is only legal in OUT_IDLE. Otherwise it is the error case above.

## Configuration
- MANO_IO_INFIFO_EN defined:
  - A FIFO_DEPTH input buffer sits in front of INPR; io_rx_ready = ~full.
  - When fgi=0 and the FIFO is non-empty, the head is popped into inpr and fgi is set. Latency from accept to fgi is 2 cycles.
  - cpu_inp and the reload never share a cycle: fgi is visibly 0 for at least one cycle between characters.
  - Simultaneous push and pop while full is not allowed, because ready=0.
- MANO_IO_INFIFO_EN undefined: direct path as described in Operation. FIFO_DEPTH is ignored.

## Structure
- Package mano_io_pkg:
  - DATA_W default.
  - Output FSM state enum (OUT_IDLE, OUT_SEND).
  - FIFO_DEPTH default and its pointer-width constant.
- Sub-module mano_io_fifo: synchronous FIFO with push/pop, full/empty and a wrap bit on the pointers. It is instantiated only under MANO_IO_INFIFO_EN.

## Test plan
- Reset: drive io_reset_n low mid-cycle. Outputs are immediately inpr=0, fgi=0, fgo=1, ien=0, tx_valid=0, err=0.
- Input: host sends 8'h41, then CPU INP after 3 cycles. Required response:
  - fgi=1 and inpr=8'h41 one cycle after the accept (two cycles with FIFO).
  - rx_ready=0 while fgi=1.
  - fgi=0 after INP.
- Output with backpressure: OUT with ac=8'h5A while tx_ready is held low for 5 cycles. tx_data stays 8'h5A and fgo stays 0 throughout; fgo=1 after the ready cycle.
- Interrupts:
  - ION, then deliver a character: int_req=1.
  - int_ack: ien=0 and int_req=0 next cycle.
  - ion and iof in the same cycle: ien=0.
- Errors: INP with fgi=0, or OUT while in OUT_SEND, sets err=1 permanently. inpr and OUTR are unchanged.
- FIFO build: burst of 5 characters 8'h01..8'h05 with depth 4. Required response:
  - rx_ready drops at the point the burst exceeds 4 buffered characters.
  - Four INPs read 01, 02, 03, 04 in order, then 05, with no loss or duplication.

Source files
------------

// File: rtl/mano_io_pkg.sv
// Shared defaults and types for the Mano machine character I/O controller.
package mano_io_pkg;

  localparam int unsigned IO_DATA_W     = 8;
  localparam int unsigned IO_FIFO_DEPTH = 4;
  localparam int unsigned IO_FIFO_PTR_W = $clog2(IO_FIFO_DEPTH);

  typedef enum logic [0:0] {
    OUT_IDLE,
    OUT_SEND
  } out_state_e;

endpackage

// File: rtl/mano_io_fifo.sv
// Synchronous FIFO used as the optional input buffer in front of INPR.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module mano_io_fifo
  import mano_io_pkg::*;
#(
  parameter int unsigned Width = IO_DATA_W,
  parameter int unsigned Depth = IO_FIFO_DEPTH,
  parameter int unsigned AddrW = IO_FIFO_PTR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mano_io_ctrl.sv
// Mano machine character I/O controller: INPR, FGI/FGO/IEN flags and interrupt request R.
// Define MANO_IO_INFIFO_EN to place a FIFO_DEPTH-entry input buffer in front of INPR.
module mano_io_ctrl
  import mano_io_pkg::*;
#(
  parameter int unsigned DATA_W     = IO_DATA_W,
  parameter int unsigned FIFO_DEPTH = IO_FIFO_DEPTH
) (
  input  logic              io_clock,
  input  logic              io_reset_n,
  input  logic              io_rx_valid,
  input  logic [DATA_W-1:0] io_rx_data,
  output logic              io_rx_ready,
  output logic              io_tx_valid,
  output logic [DATA_W-1:0] io_tx_data,
  input  logic              io_tx_ready,
  input  logic              io_cpu_inp,
  input  logic              io_cpu_out,
  input  logic [DATA_W-1:0] io_cpu_ac,
  input  logic              io_cpu_ion,
  input  logic              io_cpu_iof,
  input  logic              io_cpu_int_ack,
  output logic [DATA_W-1:0] io_inpr,
  output logic              io_fgi,
  output logic              io_fgo,
  output logic              io_ien,
  output logic              io_int_req,
  output logic              io_err
);

  out_state_e        out_state_q;
  logic [DATA_W-1:0] inpr_q, outr_q, inpr_src;
  logic              fgi_q, fgo_q, ien_q, tx_valid_q, err_q;
  logic              inpr_load, inp_ok, inp_err, out_err;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mano_io_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  assign inp_ok  = io_cpu_inp & fgi_q;
  assign inp_err = io_cpu_inp & ~fgi_q;
  assign out_err = io_cpu_out & (out_state_q == OUT_SEND);

`ifdef MANO_IO_INFIFO_EN
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // Reload only while fgi is clear, so it can never share a cycle with a legal INP.
  assign inpr_load   = ~fgi_q & ~fifo_empty;
  assign inpr_src    = fifo_rdata;
  assign io_rx_ready = ~fifo_full;

  mano_io_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH),
    .AddrW ($clog2(FIFO_DEPTH))
  ) u_in_fifo (
    .clk_i   (io_clock),
    .rst_ni  (io_reset_n),
    .push_i  (io_rx_valid),
    .wdata_i (io_rx_data),
    .pop_i   (inpr_load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
`else
  assign io_rx_ready = ~fgi_q;
  assign inpr_load   = io_rx_valid & ~fgi_q;
  assign inpr_src    = io_rx_data;
`endif

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
    end else if (inpr_load) begin
      inpr_q <= inpr_src;
      fgi_q  <= 1'b1;
    end else if (inp_ok) begin
      fgi_q  <= 1'b0;
    end
  end

  // Output FSM; fgo and tx_valid are registered alongside the state.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      out_state_q <= OUT_IDLE;
      outr_q      <= '0;
      tx_valid_q  <= 1'b0;
      fgo_q       <= 1'b1;
    end else begin
      unique case (out_state_q)
        OUT_IDLE: begin
          if (io_cpu_out) begin
            outr_q      <= io_cpu_ac;
            out_state_q <= OUT_SEND;
            tx_valid_q  <= 1'b1;
            fgo_q       <= 1'b0;
          end
        end
        OUT_SEND: begin
          if (io_tx_ready) begin
            out_state_q <= OUT_IDLE;
            tx_valid_q  <= 1'b0;
            fgo_q       <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      ien_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (io_cpu_int_ack || io_cpu_iof) begin
        ien_q <= 1'b0;
      end else if (io_cpu_ion) begin
        ien_q <= 1'b1;
      end
      if (inp_err || out_err) err_q <= 1'b1;
    end
  end

  assign io_inpr     = inpr_q;
  assign io_fgi      = fgi_q;
  assign io_fgo      = fgo_q;
  assign io_ien      = ien_q;
  assign io_tx_valid = tx_valid_q;
  assign io_tx_data  = outr_q;
  assign io_err      = err_q;
  assign io_int_req  = ien_q & (fgi_q | fgo_q);

endmodule

// File: tb/tb_mano_io_ctrl.sv
// Self-checking bench for mano_io_ctrl: IEN priority vector table, scoreboarded rx/tx
// character streams and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_mano_io_ctrl;

  localparam int unsigned W = 8;

  logic         io_clock = 1'b0;
  logic         io_reset_n = 1'b0;
  logic         io_rx_valid = 1'b0;
  logic [W-1:0] io_rx_data = '0;
  logic         io_rx_ready;
  logic         io_tx_valid;
  logic [W-1:0] io_tx_data;
  logic         io_tx_ready = 1'b0;
  logic         io_cpu_inp = 1'b0;
  logic         io_cpu_out = 1'b0;
  logic [W-1:0] io_cpu_ac = '0;
  logic         io_cpu_ion = 1'b0;
  logic         io_cpu_iof = 1'b0;
  logic         io_cpu_int_ack = 1'b0;
  logic [W-1:0] io_inpr;
  logic         io_fgi, io_fgo, io_ien, io_int_req, io_err;

  always #5 io_clock = ~io_clock;

  mano_io_ctrl #(
    .DATA_W     (W),
    .FIFO_DEPTH (4)
  ) dut (
    .io_clock       (io_clock),
    .io_reset_n     (io_reset_n),
    .io_rx_valid    (io_rx_valid),
    .io_rx_data     (io_rx_data),
    .io_rx_ready    (io_rx_ready),
    .io_tx_valid    (io_tx_valid),
    .io_tx_data     (io_tx_data),
    .io_tx_ready    (io_tx_ready),
    .io_cpu_inp     (io_cpu_inp),
    .io_cpu_out     (io_cpu_out),
    .io_cpu_ac      (io_cpu_ac),
    .io_cpu_ion     (io_cpu_ion),
    .io_cpu_iof     (io_cpu_iof),
    .io_cpu_int_ack (io_cpu_int_ack),
    .io_inpr        (io_inpr),
    .io_fgi         (io_fgi),
    .io_fgo         (io_fgo),
    .io_ien         (io_ien),
    .io_int_req     (io_int_req),
    .io_err         (io_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] rx_q[$];
  logic [W-1:0] tx_q[$];
  logic [W-1:0] last_inpr = '0;

`ifdef MANO_IO_INFIFO_EN
  localparam bit FifoBuild = 1'b1;
`else
  localparam bit FifoBuild = 1'b0;
`endif

  typedef struct {
    logic ion;
    logic iof;
    logic ack;
    logic exp_ien;
  } ien_vec_t;

  ien_vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  // Host sends one character, waiting (bounded) for rx_ready.
  task automatic send_char(input logic [W-1:0] c);
    io_rx_valid = 1'b1;
    io_rx_data  = c;
    for (int i = 0; i < 20 && !io_rx_ready; i++) tick();
    if (!io_rx_ready) fail_now("send_char");
    else rx_q.push_back(c);
    tick();
    io_rx_valid = 1'b0;
  endtask

  task automatic wait_fgi();
    for (int i = 0; i < 20 && !io_fgi; i++) tick();
    if (!io_fgi) fail_now("wait_fgi");
  endtask

  // CPU INP: inpr must hold the oldest accepted character; fgi clears afterwards.
  task automatic cpu_inp_read();
    logic [W-1:0] exp;
    wait_fgi();
    if (rx_q.size() == 0) begin
      fail_now("inp_no_expected_char");
    end else begin
      exp = rx_q.pop_front();
      check("inp_inpr", io_inpr, exp);
      last_inpr = exp;
    end
    io_cpu_inp = 1'b1;
    tick();
    io_cpu_inp = 1'b0;
    check("inp_fgi_clear", io_fgi, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inpr"}, io_inpr, 0);
    check({tag, "_fgi"}, io_fgi, 0);
    check({tag, "_fgo"}, io_fgo, 1);
    check({tag, "_ien"}, io_ien, 0);
    check({tag, "_tx_valid"}, io_tx_valid, 0);
    check({tag, "_err"}, io_err, 0);
    check({tag, "_int_req"}, io_int_req, 0);
  endtask

  // tx scoreboard: compare each completed handshake against the queued OUT value.
  always @(negedge io_clock) begin
    if (io_reset_n && io_tx_valid && io_tx_ready) begin
      if (tx_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no transfer", io_tx_data);
      end else begin
        check("tx_data", io_tx_data, tx_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // IEN priority: int_ack > iof > ion. fgi=0, fgo=1 throughout, so int_req tracks ien.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    #12;
    check_reset_values("rst");
    check("rst_rx_ready", io_rx_ready, 1);
    @(negedge io_clock);
    io_reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      io_cpu_ion     = vecs[i].ion;
      io_cpu_iof     = vecs[i].iof;
      io_cpu_int_ack = vecs[i].ack;
      tick();
      io_cpu_ion     = 1'b0;
      io_cpu_iof     = 1'b0;
      io_cpu_int_ack = 1'b0;
      check($sformatf("ien_vec%0d", i), io_ien, vecs[i].exp_ien);
      check($sformatf("int_req_vec%0d", i), io_int_req, vecs[i].exp_ien);
    end

    // Input path: 'A' then INP three cycles later
    io_rx_valid = 1'b1;
    io_rx_data  = 8'h41;
    check("rx_ready_idle", io_rx_ready, 1);
    tick();
    rx_q.push_back(8'h41);
    io_rx_valid = 1'b0;
    if (FifoBuild) begin
      check("fgi_fifo_latency", io_fgi, 0);
      tick();
    end
    check("rx_fgi_set", io_fgi, 1);
    check("rx_inpr", io_inpr, 8'h41);
    for (int i = 0; i < 3; i++) begin
      check("rx_ready_while_fgi", io_rx_ready, FifoBuild ? 1 : 0);
      tick();
    end
    cpu_inp_read();
    check("rx_ready_after_inp", io_rx_ready, 1);
    check("err_after_good_inp", io_err, 0);

    // Output with 5 cycles of backpressure
    io_tx_ready = 1'b0;
    io_cpu_out  = 1'b1;
    io_cpu_ac   = 8'h5A;
    tx_q.push_back(8'h5A);
    tick();
    io_cpu_out = 1'b0;
    io_cpu_ac  = 8'h00;
    check("out_tx_valid", io_tx_valid, 1);
    check("out_fgo_low", io_fgo, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_tx_data", io_tx_data, 8'h5A);
      check("bp_fgo", io_fgo, 0);
      tick();
    end
    io_tx_ready = 1'b1;
    tick();
    check("bp_fgo_done", io_fgo, 1);
    check("bp_tx_valid_done", io_tx_valid, 0);

    // Output with tx_ready already high: handshake at N+1
    io_cpu_out = 1'b1;
    io_cpu_ac  = 8'hC3;
    tx_q.push_back(8'hC3);
    tick();
    io_cpu_out = 1'b0;
    check("fast_fgo_n", io_fgo, 0);
    check("fast_tx_valid_n", io_tx_valid, 1);
    tick();
    check("fast_fgo_n1", io_fgo, 1);
    io_tx_ready = 1'b0;

    // Interrupts: keep fgo low so int_req comes only from the delivered character
    io_cpu_out = 1'b1;
    io_cpu_ac  = 8'h3C;
    tx_q.push_back(8'h3C);
    tick();
    io_cpu_out = 1'b0;
    io_cpu_ion = 1'b1;
    tick();
    io_cpu_ion = 1'b0;
    check("irq_ien_on", io_ien, 1);
    check("irq_idle_req", io_int_req, 0);
    send_char(8'h55);
    wait_fgi();
    check("irq_req_on_char", io_int_req, 1);
    io_cpu_int_ack = 1'b1;
    tick();
    io_cpu_int_ack = 1'b0;
    check("irq_ack_ien", io_ien, 0);
    check("irq_ack_req", io_int_req, 0);
    io_tx_ready = 1'b1;
    tick();
    io_tx_ready = 1'b0;
    cpu_inp_read();

`ifdef MANO_IO_INFIFO_EN
    // Burst of 5 into a depth-4 FIFO: INPR takes the first, the FIFO the rest
    for (int k = 1; k <= 5; k++) begin
      io_rx_valid = 1'b1;
      io_rx_data  = W'(k);
      check("burst_ready", io_rx_ready, 1);
      tick();
      rx_q.push_back(W'(k));
    end
    io_rx_valid = 1'b0;
    check("burst_full_ready", io_rx_ready, 0);
    for (int k = 0; k < 5; k++) cpu_inp_read();
    check("burst_ready_drained", io_rx_ready, 1);
`endif

    // Errors: INP with fgi=0, then OUT while OUT_SEND
    io_cpu_inp = 1'b1;
    tick();
    io_cpu_inp = 1'b0;
    check("err_inp", io_err, 1);
    check("err_inp_inpr", io_inpr, last_inpr);
    check("err_inp_fgi", io_fgi, 0);
    io_cpu_out = 1'b1;
    io_cpu_ac  = 8'h11;
    tx_q.push_back(8'h11);
    tick();
    io_cpu_ac = 8'h22;
    tick();
    io_cpu_out = 1'b0;
    check("err_out_outr", io_tx_data, 8'h11);
    check("err_out_fgo", io_fgo, 0);
    io_tx_ready = 1'b1;
    tick();
    io_tx_ready = 1'b0;
    tick();
    tick();
    check("err_sticky", io_err, 1);
    check("err_no_dup_tx", io_tx_valid, 0);

    // Reset mid-cycle with a character held and a tx pending
    io_cpu_ion = 1'b1;
    tick();
    io_cpu_ion = 1'b0;
    send_char(8'h99);
    wait_fgi();
    io_cpu_out = 1'b1;
    io_cpu_ac  = 8'hEE;
    tick();
    io_cpu_out = 1'b0;
    check("pre_rst_tx_valid", io_tx_valid, 1);
    @(posedge io_clock);
    #3;
    io_reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    rx_q.delete();
    @(negedge io_clock);
    io_reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_tx_valid", io_tx_valid, 0);
    check("post_rst_err", io_err, 0);

    check("rx_queue_empty", rx_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
